// File: rtl/inst_issuer.sv
// Instruction issuer: buffers host instructions in a small FIFO, issues one per
// cycle to the pipeline, and on flush drains the pipeline with NOPs before
// reading back the four architectural registers through the debug port.
module inst_issuer #(
    parameter int DEPTH        = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_inst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [7:0]  inst,
    output logic [1:0]  dummy_read_rf,
    input  logic [7:0]  dummy_rf_data,
    output logic [7:0]  r0,
    output logic [7:0]  r1,
    output logic [7:0]  r2,
    output logic [7:0]  r3,
    output logic        snap_valid,
    output logic        busy,
    output logic [15:0] issue_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [15:0]   DRAIN_C = 16'(DRAIN_CYCLES);

    typedef enum logic [1:0] {ISSUE, DRAIN, READ, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          flush_pend_q, flush_pend_d;
    logic [15:0]   drain_q, drain_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    inst_q, inst_d;
    logic [7:0]    snap_q [4];
    logic [7:0]    snap_d [4];
    logic          snap_valid_q, snap_valid_d;
    logic [15:0]   issue_cnt_q, issue_cnt_d;
    logic [7:0]    mem_q [DEPTH];

    logic push;
    logic pop;

    // Acceptance is closed while in reset, while a flush is pending and when full;
    // a simultaneous pop does not reopen a full FIFO.
    assign in_ready = rst && (state_q == ISSUE) && !flush_pend_q && (count_q < DEPTH_C);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == ISSUE) && (count_q != '0);

    assign inst          = inst_q;
    assign dummy_read_rf = (state_q == READ) ? idx_q : 2'b00;
    assign r0            = snap_q[0];
    assign r1            = snap_q[1];
    assign r2            = snap_q[2];
    assign r3            = snap_q[3];
    assign snap_valid    = snap_valid_q;
    assign busy          = (state_q != ISSUE);
    assign issue_cnt     = issue_cnt_q;

    // Next-state logic for FIFO pointers, issue path, flush sequencing and snapshot.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d      = count_q;
        flush_pend_d = flush_pend_q;
        drain_d      = drain_q;
        idx_d        = idx_q;
        inst_d       = 8'h00;
        snap_d       = snap_q;
        snap_valid_d = 1'b0;
        issue_cnt_d  = issue_cnt_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ISSUE: begin
                if (pop) begin
                    inst_d = mem_q[rd_ptr_q];
                    if (issue_cnt_q != 16'hFFFF) begin
                        issue_cnt_d = issue_cnt_q + 16'd1;
                    end
                end
                // Drain only starts once every buffered word has been issued.
                if (flush_pend_q && (count_q == '0)) begin
                    state_d      = DRAIN;
                    flush_pend_d = 1'b0;
                    drain_d      = DRAIN_C;
                end else if (flush) begin
                    flush_pend_d = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q <= 16'd1) begin
                    state_d = READ;
                    idx_d   = 2'd0;
                end else begin
                    drain_d = drain_q - 16'd1;
                end
            end
            READ: begin
                snap_d[idx_q] = dummy_rf_data;
                idx_d         = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d      = DONE;
                    snap_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = ISSUE;
            end
            default: begin
                state_d = ISSUE;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ISSUE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            flush_pend_q <= 1'b0;
            drain_q      <= '0;
            idx_q        <= 2'd0;
            inst_q       <= 8'h00;
            snap_q       <= '{default: 8'h00};
            snap_valid_q <= 1'b0;
            issue_cnt_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            flush_pend_q <= flush_pend_d;
            drain_q      <= drain_d;
            idx_q        <= idx_d;
            inst_q       <= inst_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            issue_cnt_q  <= issue_cnt_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_inst;
        end
    end

endmodule

// File: tb/tb_inst_issuer.sv
// Bench for inst_issuer: a register-file pipeline stub, a scoreboard monitor
// driven by issue_cnt steps and snap_valid, plus directed flush/reset/saturation runs.
module tb_inst_issuer;

    localparam int DEPTH = 4;
    localparam int DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_inst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [7:0]  inst;
    logic [1:0]  dummy_read_rf;
    logic [7:0]  dummy_rf_data;
    logic [7:0]  r0, r1, r2, r3;
    logic        snap_valid;
    logic        busy;
    logic [15:0] issue_cnt;

    always #5 clk = ~clk;

    inst_issuer #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst), .in_inst(in_inst), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .inst(inst),
        .dummy_read_rf(dummy_read_rf), .dummy_rf_data(dummy_rf_data),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .snap_valid(snap_valid),
        .busy(busy), .issue_cnt(issue_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    int          snaps  = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  exp_q [$];
    logic [15:0] cnt_model = 16'h0;
    logic [7:0]  rf     [4] = '{8'h3c, 8'h5a, 8'h17, 8'hc4};
    logic [7:0]  rf_ref [4] = '{8'h3c, 8'h5a, 8'h17, 8'hc4};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exec(input logic [7:0] w, input logic [7:0] a, input logic [7:0] b);
        case (w[7:6])
            2'b01:   return a + b;
            2'b10:   return a - b;
            2'b11:   return a & b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rand_op();
        logic [1:0] op;
        op = 2'(1 + $urandom_range(0, 2));
        return {op, 6'($urandom)};
    endfunction

    // Pipeline stub: executes every issued word one cycle later; debug port is combinational.
    always @(posedge clk) begin
        if (inst[7:6] != 2'b00) rf[inst[5:4]] <= exec(inst, rf[inst[3:2]], rf[inst[1:0]]);
    end
    assign dummy_rf_data = rf[dummy_read_rf];

    // Scoreboard: record accepted words at the edge, check issues/snapshots mid-cycle.
    always begin
        logic [7:0] w;
        @(posedge clk);
        if (mon_en && rst && in_valid && in_ready) exp_q.push_back(in_inst);
        @(negedge clk);
        if (!rst) begin
            exp_q.delete();
            cnt_model = 16'h0;
        end else if (mon_en) begin
            if (issue_cnt != cnt_model) begin
                cnt_model = (cnt_model == 16'hFFFF) ? cnt_model : cnt_model + 16'd1;
                check("issue_cnt_step", issue_cnt, cnt_model);
                cnt_model = issue_cnt;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_issue: got inst %02h expected no issue at %0t", inst, $time);
                end else begin
                    w = exp_q.pop_front();
                    check("inst_order", inst, w);
                    if (w[7:6] != 2'b00) rf_ref[w[5:4]] = exec(w, rf_ref[w[3:2]], rf_ref[w[1:0]]);
                end
            end else begin
                check("bubble_inst", inst, 8'h00);
            end
            check("ready_rule", in_ready && (busy || exp_q.size() >= DEPTH), 0);
            if (snap_valid) begin
                snaps++;
                check("snap_r0", r0, rf_ref[0]);
                check("snap_r1", r1, rf_ref[1]);
                check("snap_r2", r2, rf_ref[2]);
                check("snap_r3", r3, rf_ref[3]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int base;
        logic [7:0] w0, w1, w2;
        rst = 1'b0; in_valid = 1'b0; in_inst = 8'h00; flush = 1'b0;
        cyc(); cyc();
        check("rst_inst", inst, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_snap_valid", snap_valid, 0);
        check("rst_issue_cnt", issue_cnt, 0);
        check("rst_dummy_rf", dummy_read_rf, 0);
        check("rst_r0", r0, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b1;
        mon_en = 1'b1;
        #1 check("ready_after_rst", in_ready, 1);

        // Three consecutive pushes into an empty FIFO.
        in_valid = 1'b1; in_inst = 8'h51; cyc(); check("lat_first", inst, 8'h00);
        in_inst = 8'h62; cyc(); check("seq_51", inst, 8'h51);
        in_inst = 8'h73; cyc(); check("seq_62", inst, 8'h62);
        in_valid = 1'b0;  cyc(); check("seq_73", inst, 8'h73);
        cyc(); check("seq_00", inst, 8'h00);
        check("seq_cnt", issue_cnt, 3);

        // Six back-to-back pushes, then random traffic.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_inst = 8'($urandom); cyc();
        end
        for (int i = 0; i < 200; i++) begin
            in_valid = ($urandom_range(0, 3) != 0); in_inst = 8'($urandom); cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        check("random_drained", exp_q.size(), 0);

        // Two words then a one-cycle flush: full drain/readback sequence.
        base = snaps;
        w0 = rand_op(); w1 = rand_op();
        in_valid = 1'b1; in_inst = w0; cyc();
        in_inst = w1; flush = 1'b1; cyc(); check("fl_w0", inst, w0);
        in_valid = 1'b0; flush = 1'b0; cyc();
        check("fl_w1", inst, w1);
        check("fl_pend_ready", in_ready, 0);
        check("fl_pend_busy", busy, 0);
        cyc();
        for (int k = 0; k < DRAIN; k++) begin
            check("drain_busy", busy, 1);
            check("drain_inst", inst, 8'h00);
            check("drain_rf_idx", dummy_read_rf, 0);
            check("drain_ready", in_ready, 0);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            check("read_idx", dummy_read_rf, i);
            check("read_snap_low", snap_valid, 0);
            cyc();
        end
        check("done_snap", snap_valid, 1);
        check("done_inst", inst, 8'h00);
        cyc();
        check("after_snap", snap_valid, 0);
        check("after_busy", busy, 0);
        check("snap_count_a", snaps - base, 1);

        // Flush held through pending and busy states: only one readback.
        base = snaps;
        in_valid = 1'b1; in_inst = rand_op(); flush = 1'b1; cyc();
        in_valid = 1'b0;
        repeat (8) cyc();
        flush = 1'b0;
        repeat (20) cyc();
        check("snap_count_b", snaps - base, 1);
        check("idle_busy", busy, 0);

        // Reset in the middle of readback, at index 2.
        flush = 1'b1; cyc(); flush = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (dummy_read_rf == 2'd2) break;
            cyc();
        end
        check("reach_read2", dummy_read_rf, 2);
        rst = 1'b0; cyc();
        check("mrst_inst", inst, 8'h00);
        check("mrst_busy", busy, 0);
        check("mrst_snap_valid", snap_valid, 0);
        check("mrst_issue_cnt", issue_cnt, 0);
        check("mrst_dummy_rf", dummy_read_rf, 0);
        check("mrst_r0", r0, 0);
        check("mrst_r1", r1, 0);
        check("mrst_r2", r2, 0);
        check("mrst_r3", r3, 0);
        check("mrst_in_ready", in_ready, 0);
        rst = 1'b1;
        w2 = rand_op();
        in_valid = 1'b1; in_inst = w2; cyc();
        in_valid = 1'b0; cyc();
        check("post_rst_issue", inst, w2);
        check("post_rst_cnt", issue_cnt, 1);
        cyc();
        check("total_snaps", snaps, 2);
        check("all_issued", exp_q.size(), 0);

        // Saturation of the issue counter.
        mon_en = 1'b0;
        cyc();
        force dut.issue_cnt_q = 16'hFFFE;
        cyc();
        release dut.issue_cnt_q;
        check("sat_preset", issue_cnt, 16'hFFFE);
        w0 = rand_op(); w1 = rand_op(); w2 = rand_op();
        in_valid = 1'b1; in_inst = w0; cyc();
        in_inst = w1; cyc(); check("sat_w0", inst, w0); check("sat_cnt1", issue_cnt, 16'hFFFF);
        in_inst = w2; cyc(); check("sat_w1", inst, w1); check("sat_cnt2", issue_cnt, 16'hFFFF);
        in_valid = 1'b0; cyc(); check("sat_w2", inst, w2); check("sat_cnt3", issue_cnt, 16'hFFFF);
        cyc(); check("sat_idle", inst, 8'h00); check("sat_hold", issue_cnt, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
